// File: rtl/fw_rom_arbiter_if.sv
// fw_rom_arbiter_if: sensor request/read bus plus the ROM port of fw_rom_arbiter.
// slave = arbiter side, master = sensor FSMs and ROM side.
interface fw_rom_arbiter_if #(
  parameter int NB_OF_SENSORS = 8,
  parameter int ADDR_W        = 17,
  parameter int DATA_W        = 16
);
  logic [NB_OF_SENSORS-1:0]        req;
  logic [NB_OF_SENSORS-1:0]        done;
  logic [NB_OF_SENSORS-1:0]        rd_en;
  logic [NB_OF_SENSORS*ADDR_W-1:0] addr_in;
  logic [NB_OF_SENSORS-1:0]        grant;
  logic [ADDR_W-1:0]               rom_addr;
  logic                            rom_en;
  logic [DATA_W-1:0]               rom_data;
  logic [DATA_W-1:0]               data_out;
  logic [NB_OF_SENSORS-1:0]        data_valid;
  logic                            busy;
  logic [NB_OF_SENSORS-1:0]        timeout_err;

  modport slave (
    input  req, done, rd_en, addr_in, rom_data,
    output grant, rom_addr, rom_en, data_out, data_valid, busy, timeout_err
  );

  modport master (
    output req, done, rd_en, addr_in, rom_data,
    input  grant, rom_addr, rom_en, data_out, data_valid, busy, timeout_err
  );
endinterface

// File: rtl/fw_rom_arbiter.sv
// fw_rom_arbiter: round-robin burst ownership of the shared firmware ROM among ToF sensor FSMs.
// Define FW_ARB_TIMEOUT_EN to build the ownership watchdog (MAX_HOLD owner cycles).
//
// state | meaning
// IDLE  | no owner; next requester picked at or after rr_ptr
// OWN   | one sensor owns the ROM port; its address/read strobe are registered
// DRAIN | owner released; waiting for its in-flight reads to reach data_valid
module fw_rom_arbiter #(
  parameter int NB_OF_SENSORS = 8,
  parameter int ADDR_W        = 17,
  parameter int DATA_W        = 16,
  parameter int ROM_LATENCY   = 1,
  parameter int MAX_HOLD      = 65535
) (
  input  logic            clk,
  input  logic            reset,
  fw_rom_arbiter_if.slave bus
);

  localparam int IDX_W  = (NB_OF_SENSORS > 1) ? $clog2(NB_OF_SENSORS) : 1;
  localparam int PIPE_D = 1 + ROM_LATENCY;
  localparam logic [NB_OF_SENSORS-1:0] ONE_HOT0 = NB_OF_SENSORS'(1);

  if (MAX_HOLD < 1 || ROM_LATENCY < 1) begin : g_param_check
    $error("fw_rom_arbiter: MAX_HOLD and ROM_LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         owner, owner_nxt;
  logic [IDX_W-1:0]         rr_ptr, rr_ptr_nxt;
  logic [NB_OF_SENSORS-1:0] grant_nxt;
  logic [ADDR_W-1:0]        rom_addr_nxt;
  logic                     rom_en_nxt;
  logic [NB_OF_SENSORS-1:0] issue_tag;
  logic [NB_OF_SENSORS-1:0] vpipe [PIPE_D];

  logic                     pick_found;
  logic [IDX_W-1:0]         pick_idx;
  logic [IDX_W-1:0]         cand;

  logic                     own_req, own_done, own_rd;
  logic [ADDR_W-1:0]        own_addr;
  logic                     release_c;
  logic                     timeout_hit;
  logic                     pipe_pending;

  assign own_req   = bus.req[owner];
  assign own_done  = bus.done[owner];
  assign own_rd    = bus.rd_en[owner];
  assign own_addr  = bus.addr_in[int'(owner)*ADDR_W +: ADDR_W];
  assign release_c = own_done | ~own_req | timeout_hit;

  assign bus.data_out   = bus.rom_data;
  assign bus.data_valid = vpipe[PIPE_D-1];
  assign bus.busy       = (state != IDLE);

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NB_OF_SENSORS; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NB_OF_SENSORS);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // the output stage shifts out on the IDLE transition edge, so only earlier stages block it
  always_comb begin
    pipe_pending = 1'b0;
    for (int i = 0; i < PIPE_D-1; i++) begin
      pipe_pending = pipe_pending | (|vpipe[i]);
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    grant_nxt    = bus.grant;
    rom_addr_nxt = bus.rom_addr;
    rom_en_nxt   = 1'b0;
    issue_tag    = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = OWN;
          owner_nxt = pick_idx;
          grant_nxt = ONE_HOT0 << pick_idx;
        end
      end
      OWN: begin
        rom_addr_nxt = own_addr;
        rom_en_nxt   = own_rd;
        if (own_rd) begin
          issue_tag = bus.grant;
        end
        if (release_c) begin
          state_nxt = DRAIN;
          grant_nxt = '0;
        end
      end
      DRAIN: begin
        if (!pipe_pending) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = IDX_W'((int'(owner) + 1) % NB_OF_SENSORS);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      bus.grant    <= '0;
      bus.rom_addr <= '0;
      bus.rom_en   <= 1'b0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      rr_ptr       <= rr_ptr_nxt;
      bus.grant    <= grant_nxt;
      bus.rom_addr <= rom_addr_nxt;
      bus.rom_en   <= rom_en_nxt;
    end
  end

  // owner tag of each issued read travels alongside the ROM latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_D; i++) begin
        vpipe[i] <= '0;
      end
    end else begin
      vpipe[0] <= issue_tag;
      for (int i = 1; i < PIPE_D; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
    end
  end

`ifdef FW_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;

  // down-counter reloaded outside OWN; terminal count marks the MAX_HOLD-th owner cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state != OWN) begin
      hold_cnt <= HOLD_W'(MAX_HOLD - 1);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  assign timeout_hit = (state == OWN) && (hold_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.timeout_err <= '0;
    end else if (timeout_hit) begin
      bus.timeout_err <= bus.timeout_err | bus.grant;
    end
  end
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = '0;
`endif

endmodule

// File: tb/tb_fw_rom_arbiter.sv
// tb_fw_rom_arbiter: randomized round-robin bursts against a queue scoreboard and a behavioural ROM.
`timescale 1ns/1ps
module tb_fw_rom_arbiter;
  localparam int NB   = 8;
  localparam int AW   = 17;
  localparam int DW   = 16;
  localparam int LAT  = 1;
  localparam int HOLD = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fw_rom_arbiter_if #(.NB_OF_SENSORS(NB), .ADDR_W(AW), .DATA_W(DW)) bus ();

  fw_rom_arbiter #(
    .NB_OF_SENSORS(NB), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(LAT), .MAX_HOLD(HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int rr_m     = 0;

  int              exp_tag_q  [$];
  logic [DW-1:0]   exp_data_q [$];
  logic [AW-1:0]   exp_addr_q [$];

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return DW'(a) ^ 16'hA5C3 ^ {a[16], 15'd0};
  endfunction

  function automatic logic [NB-1:0] onehot(input int i);
    logic [NB-1:0] v;
    v = '0;
    if (i >= 0 && i < NB) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick(input logic [NB-1:0] m, input int rr);
    int idx;
    for (int k = 0; k < NB; k++) begin
      idx = (rr + k) % NB;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  // single-port ROM, one clock read latency
  always @(posedge clk) begin
    if (bus.rom_en === 1'b1) bus.rom_data <= rom_word(bus.rom_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every ROM read and every data_valid must match the oldest expectation
  int            m_tag;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.rom_en === 1'b1) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL rom_read: got unexpected read at 0x%0h, expected none", bus.rom_addr);
        end else begin
          m_addr = exp_addr_q.pop_front();
          if (bus.rom_addr !== m_addr) begin
            failures++;
            $display("FAIL rom_addr: got 0x%0h expected 0x%0h", bus.rom_addr, m_addr);
          end
        end
      end
      if (bus.data_valid !== '0) begin
        checks++;
        if (exp_tag_q.size() == 0) begin
          failures++;
          $display("FAIL data_valid: got unexpected 0x%0h, expected none", bus.data_valid);
        end else begin
          m_tag  = exp_tag_q.pop_front();
          m_data = exp_data_q.pop_front();
          if (bus.data_valid !== onehot(m_tag) || bus.data_out !== m_data) begin
            failures++;
            $display("FAIL read_data: got valid=0x%0h data=0x%0h expected valid=0x%0h data=0x%0h",
                     bus.data_valid, bus.data_out, onehot(m_tag), m_data);
          end
        end
        checks++;
        if (bus.grant !== '0 && bus.grant !== bus.data_valid) begin
          failures++;
          $display("FAIL valid_overlap: got grant=0x%0h with valid=0x%0h expected no foreign grant",
                   bus.grant, bus.data_valid);
        end
      end
    end
  end

  // drive one cycle: owner reads or not; non-owners make noise, sensor 5 always targets 0x55
  task automatic drive_cycle(input int own, input bit rd, input bit force_addr, input logic [AW-1:0] faddr);
    logic [AW-1:0]    a;
    logic [NB*AW-1:0] av;
    logic [NB-1:0]    rv;
    rv = NB'($urandom);
    av = '0;
    for (int j = 0; j < NB; j++) av[j*AW +: AW] = AW'($urandom);
    rv[5] = 1'b1;
    av[5*AW +: AW] = 17'h00055;
    a = force_addr ? faddr : AW'($urandom);
    if (a == 17'h00055) a = 17'h00056;
    av[own*AW +: AW] = a;
    rv[own] = rd;
    bus.addr_in = av;
    bus.rd_en   = rv;
    if (rd) begin
      exp_addr_q.push_back(a);
      exp_tag_q.push_back(own);
      exp_data_q.push_back(rom_word(a));
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (bus.busy !== 1'b0 && g < 30) begin
      g++;
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_wait: got busy=%b after %0d cycles expected 0", bus.busy, g);
    end
  endtask

  // starts at a negedge where grant already shows own; ends at the negedge after release
  task automatic run_burst(input int own, input int ncyc, input bit use_done, input bit rd_rel, input bit dir);
    for (int c = 0; c < ncyc; c++) begin
      if (dir && c == 1) begin
        chk("single_rom_addr", 64'(bus.rom_addr), 64'h10);
        chk("single_rom_en", 64'(bus.rom_en), 64'h1);
      end
      if (dir && c == 2) begin
        chk("single_valid", 64'(bus.data_valid), 64'h08);
        chk("single_data", 64'(bus.data_out), 64'(rom_word(17'h00010)));
      end
      chk("owner_grant", 64'(bus.grant), 64'(onehot(own)));
      chk("owner_busy", 64'(bus.busy), 64'h1);
      drive_cycle(own, (dir && c == 0) ? 1'b1 : 1'($urandom_range(0, 1)), dir && c == 0, 17'h00010);
      @(negedge clk);
    end
    drive_cycle(own, rd_rel, 1'b0, '0);
    if (use_done) bus.done[own] = 1'b1;
    else          bus.req[own]  = 1'b0;
    @(negedge clk);
    bus.done    = '0;
    bus.req[own] = 1'b0;
    bus.rd_en   = '0;
    chk("release_grant", 64'(bus.grant), 64'h0);
  endtask

  task automatic round(input logic [NB-1:0] mask, input bit forced, input bit dir);
    logic [NB-1:0] pend;
    int own, zeros, busy_low, ncyc;
    bit ud, rrel;
    pend = mask;
    wait_idle();
    bus.req = mask;
    @(negedge clk);
    own = pick(pend, rr_m);
    chk("grant_latency", 64'(bus.grant), 64'(onehot(own)));
    while (pend != '0) begin
      ncyc = (forced || dir) ? 4 : int'($urandom_range(1, 5));
      ud   = (forced || dir) ? 1'b1 : 1'($urandom_range(0, 1));
      rrel = forced ? 1'b1 : 1'($urandom_range(0, 1));
      run_burst(own, ncyc, ud, rrel, dir);
      pend[own] = 1'b0;
      rr_m = (own + 1) % NB;
      if (pend != '0) begin
        zeros    = 0;
        busy_low = 0;
        while (bus.grant == '0 && zeros < 20) begin
          zeros++;
          if (bus.busy == 1'b0) busy_low++;
          @(negedge clk);
        end
        checks++;
        if (zeros < 2 || zeros > 2 + LAT) begin
          failures++;
          $display("FAIL arb_gap: got %0d ungranted cycles expected 2..%0d", zeros, 2 + LAT);
        end
        chk("idle_gap", 64'(busy_low), 64'd1);
        own = pick(pend, rr_m);
        chk("grant_order", 64'(bus.grant), 64'(onehot(own)));
      end
    end
  endtask

  initial begin
    int own, held, g;
    reset       = 1'b1;
    bus.req     = '0;
    bus.done    = '0;
    bus.rd_en   = '0;
    bus.addr_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(bus.grant), 64'h0);
    chk("rst_rom_addr", 64'(bus.rom_addr), 64'h0);
    chk("rst_rom_en", 64'(bus.rom_en), 64'h0);
    chk("rst_valid", 64'(bus.data_valid), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_timeout", 64'(bus.timeout_err), 64'h0);
    reset = 1'b0;
    @(negedge clk);

    round(8'hFF, 1'b1, 1'b0);
    round(8'h01, 1'b0, 1'b0);
    round(8'h08, 1'b0, 1'b1);
    for (int r = 0; r < 25; r++) round(NB'($urandom_range(1, 255)), 1'b0, 1'b0);

    // reset with two reads in flight
    wait_idle();
    bus.req = 8'h80;
    @(negedge clk);
    own = pick(8'h80, rr_m);
    chk("pre_rst_grant", 64'(bus.grant), 64'(onehot(own)));
    drive_cycle(own, 1'b1, 1'b0, '0);
    @(negedge clk);
    drive_cycle(own, 1'b1, 1'b0, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    exp_addr_q.delete();
    exp_tag_q.delete();
    exp_data_q.delete();
    rr_m = 0;
    chk("mid_rst_grant", 64'(bus.grant), 64'h0);
    chk("mid_rst_rom_addr", 64'(bus.rom_addr), 64'h0);
    chk("mid_rst_rom_en", 64'(bus.rom_en), 64'h0);
    chk("mid_rst_valid", 64'(bus.data_valid), 64'h0);
    chk("mid_rst_busy", 64'(bus.busy), 64'h0);
    bus.req   = '0;
    bus.rd_en = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(bus.data_valid), 64'h0);
    end

`ifdef FW_ARB_TIMEOUT_EN
    bus.req = 8'h30;
    @(negedge clk);
    chk("wd_first_grant", 64'(bus.grant), 64'h10);
    held = 0;
    while (bus.grant == 8'h10 && held < 100) begin
      held++;
      @(negedge clk);
    end
    chk("wd_hold", 64'(held), 64'(HOLD));
    chk("wd_err", 64'(bus.timeout_err), 64'h10);
    bus.req[4] = 1'b0;
    rr_m = 5;
    g = 0;
    while (bus.grant == '0 && g < 20) begin
      g++;
      @(negedge clk);
    end
    chk("wd_next_grant", 64'(bus.grant), 64'h20);
    run_burst(5, 2, 1'b1, 1'b0, 1'b0);
    rr_m = 6;
    wait_idle();
    chk("wd_err_sticky", 64'(bus.timeout_err), 64'h10);
`else
    round(8'h30, 1'b0, 1'b0);
    held = 0;
    g    = 0;
    chk("timeout_err_off", 64'(bus.timeout_err), 64'h0);
`endif

    wait_idle();
    repeat (4) @(negedge clk);
    chk("sb_addr_empty", 64'(exp_addr_q.size()), 64'd0);
    chk("sb_data_empty", 64'(exp_tag_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
